seg_scan_controller: RTL

//  Time-multiplexed scan sequencer for the 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
`timescale 1ns/1ps
// seg_scan_controller
//   Scan sequencer for a multiplexed common-anode 7-segment display.
//   Each digit owns a fixed slot of SLOT_CYCLES clocks.
//   Every slot opens with a blanked dead time to prevent ghosting.
//   A PWM on-window follows, whose length is set by brightness.
//   The rest of the slot is blanked.
//   The displayed value is double-buffered. A load lands in a shadow
//   register and is committed only on the last cycle of a frame, so a
//   frame never mixes old and new digits.
//   Timing requirements: SLOT_CYCLES >= DEAD_CYCLES + 16 and DEAD_CYCLES >= 1.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load_value   new nibbles, digit i = [4i+3:4i]
//   load_valid   load_value valid
//   load_ready   shadow buffer empty, a load will be accepted
//   digit_en     per-digit enable (0 = dark, slot still consumed)
//   brightness   PWM level 0..15, sampled at each slot start
//   digit_value  nibble for the segment decoder (registered)
//   digit_sel    one-hot active-low digit select (registered)
//   blank        1 = all segments off (registered)
//   frame_done   pulse on the last cycle of a frame
//
// state  | meaning
// S_DEAD | slot_cnt < DEAD_CYCLES, display blanked, next digit value loaded
// S_ON   | PWM on-window, enabled digit selected
// S_OFF  | remainder of slot, display blanked
module seg_scan_controller #(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 25000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [3:0]            brightness,
    output logic [3:0]            digit_value,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP  = (SLOT_CYCLES - DEAD_CYCLES) / 16;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_DEAD, S_ON, S_OFF} state_t;

    state_t                state;
    logic [CNT_W-1:0]      slot_cnt;
    logic [CNT_W-1:0]      slot_nxt;
    logic [CNT_W-1:0]      on_end;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            bright_q;
    logic [4*DIGITS-1:0]   active;
    logic [4*DIGITS-1:0]   shadow;
    logic                  shadow_full;
    logic                  slot_wrap;
    logic [DIGITS-1:0]     sel_mask;
    logic [3:0]            active_nib [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign active_nib[g] = active[4*g +: 4];
    end

    always_comb begin
        slot_wrap = (slot_cnt == SLOT_LAST);
        slot_nxt  = slot_wrap ? '0 : slot_cnt + 1'b1;
        // The on-window ends at DEAD + ON_LEN.
        // Any division remainder is left in S_OFF.
        on_end    = CNT_W'(DEAD_CYCLES + (int'(bright_q) + 1) * STEP);
        sel_mask  = ~(DIGITS'(1) << idx);
    end

    assign frame_done = slot_wrap && (idx == IDX_LAST);
    assign load_ready = ~shadow_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_DEAD;
            slot_cnt    <= '0;
            idx         <= '0;
            bright_q    <= '0;
            digit_sel   <= '1;
            blank       <= 1'b1;
            digit_value <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            if (slot_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (slot_cnt == '0)
                bright_q <= brightness;

            case (state)
                S_DEAD: begin
                    digit_sel   <= '1;
                    blank       <= 1'b1;
                    // Loaded while the display is blanked.
                    // The value is therefore stable for the whole on-window.
                    digit_value <= active_nib[idx];
                    if (slot_nxt == DEAD_END)
                        state <= S_ON;
                end
                S_ON: begin
                    if (digit_en[idx]) begin
                        digit_sel <= sel_mask;
                        blank     <= 1'b0;
                    end else begin
                        digit_sel <= '1;
                        blank     <= 1'b1;
                    end
                    if (slot_nxt == on_end)
                        state <= S_OFF;
                end
                S_OFF: begin
                    digit_sel <= '1;
                    blank     <= 1'b1;
                end
                default: state <= S_DEAD;
            endcase

            // At full brightness the on-window can reach the slot end.
            // The wrap then takes the FSM straight back to S_DEAD.
            if (slot_wrap)
                state <= S_DEAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else if (frame_done && shadow_full) begin
            active      <= shadow;
            shadow_full <= 1'b0;
        end else if (load_valid && !shadow_full) begin
            shadow      <= load_value;
            shadow_full <= 1'b1;
        end
    end

endmodule
